// File: rtl/qbert_pkg.sv
// Shared constants, enums and the decoded-position payload for the Q*bert cube tracker.
package qbert_pkg;

   localparam int unsigned N_CUBE_DEF = 28;
   localparam int unsigned IDX_W      = 5;

   typedef enum logic [1:0] {
      RULE_ONCE     = 2'd0,
      RULE_TWO_STEP = 2'd1,
      RULE_TOGGLE   = 2'd2
   } rule_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_ARMED  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SAMPLE = 3'd4,
      ST_UPDATE = 3'd5,
      ST_DONE   = 3'd6
   } tracker_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             valid;
      logic             multi;
   } cube_pos_t;

   // The reserved rule encoding behaves as ONCE.
   function automatic rule_e decode_rule(input logic [1:0] raw);
      case (raw)
         2'd1:    decode_rule = RULE_TWO_STEP;
         2'd2:    decode_rule = RULE_TOGGLE;
         default: decode_rule = RULE_ONCE;
      endcase
   endfunction

endpackage

// File: rtl/qbert_cube_index.sv
// Combinational one-hot cube position decoder: index, any-bit-set and multi-hot flag.
module qbert_cube_index
   import qbert_pkg::*;
#(
   parameter int unsigned N_CUBE = N_CUBE_DEF
) (
   input  logic [N_CUBE-1:0] onehot,
   output cube_pos_t         pos_c
);

   always_comb begin
      pos_c = '0;
      for (int unsigned i = 0; i < N_CUBE; i++) begin
         if (onehot[IDX_W'(i)]) begin
            pos_c.multi = pos_c.multi | pos_c.valid;
            pos_c.valid = 1'b1;
            pos_c.idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/qbert_cube_tracker.sv
// Tracks Q*bert landings, applies the level colouring rule per cube and flags level completion.
module qbert_cube_tracker
   import qbert_pkg::*;
#(
   parameter int unsigned N_CUBE = N_CUBE_DEF,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              CLK_33,
   input  logic              reset,
   input  logic              e_start_qb,
   input  logic              e_pause_qb,
   input  logic [1:0]        e_rule,
   input  logic              done_move,
   input  logic [3:0]        KO_qb,
   input  logic [N_CUBE-1:0] position_qb,
   output logic [N_CUBE-1:0] color_state,
   output logic [N_CUBE-1:0] mid_state,
   output logic [CNT_W-1:0]  color_cnt,
   output logic [IDX_W-1:0]  cube_idx,
   output logic              land_pulse,
   output logic              off_map,
   output logic              pos_err,
   output logic              level_done
);

   localparam int unsigned       WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_CUBE);

   tracker_state_e    state;
   rule_e             rule_q;
   logic              start_d;
   logic              done_d;
   logic              accept_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              start_rise_c;
   logic              done_rise_c;
   cube_pos_t         pos_c;
   logic [N_CUBE-1:0] color_nx_c;
   logic [N_CUBE-1:0] mid_nx_c;
   logic [CNT_W-1:0]  cnt_nx_c;

   assign start_rise_c = e_start_qb & ~start_d;
   assign done_rise_c  = done_move & ~done_d;

   qbert_cube_index #(.N_CUBE(N_CUBE)) u_index (
      .onehot (position_qb),
      .pos_c  (pos_c)
   );

   // Board state after applying the latched cube under the level rule; count tracks the change.
   always_comb begin
      color_nx_c = color_state;
      mid_nx_c   = mid_state;
      cnt_nx_c   = color_cnt;
      case (rule_q)
         RULE_TWO_STEP: begin
            if (!mid_state[cube_idx]) mid_nx_c[cube_idx] = 1'b1;
            else                      color_nx_c[cube_idx] = 1'b1;
         end
         RULE_TOGGLE: color_nx_c[cube_idx] = ~color_state[cube_idx];
         default:     color_nx_c[cube_idx] = 1'b1;
      endcase
      if (color_nx_c[cube_idx] && !color_state[cube_idx] && (color_cnt < CNT_FULL))
         cnt_nx_c = color_cnt + CNT_W'(1);
      else if (!color_nx_c[cube_idx] && color_state[cube_idx] && (color_cnt != '0))
         cnt_nx_c = color_cnt - CNT_W'(1);
   end

   // Landing FSM; pause freezes everything except the edge-detect history, so paused edges are lost.
   always_ff @(posedge CLK_33 or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         rule_q      <= RULE_ONCE;
         start_d     <= 1'b0;
         done_d      <= 1'b0;
         accept_q    <= 1'b0;
         wait_cnt    <= '0;
         color_state <= '0;
         mid_state   <= '0;
         color_cnt   <= '0;
         cube_idx    <= '0;
         land_pulse  <= 1'b0;
         off_map     <= 1'b0;
         pos_err     <= 1'b0;
         level_done  <= 1'b0;
      end else begin
         start_d    <= e_start_qb;
         done_d     <= done_move;
         land_pulse <= 1'b0;
         if (!e_pause_qb) begin
            if (start_rise_c) begin
               state    <= ST_CLEAR;
               accept_q <= 1'b0;
            end else begin
               case (state)
                  ST_CLEAR: begin
                     color_state <= '0;
                     mid_state   <= '0;
                     color_cnt   <= '0;
                     off_map     <= 1'b0;
                     pos_err     <= 1'b0;
                     level_done  <= 1'b0;
                     rule_q      <= decode_rule(e_rule);
                     state       <= ST_ARMED;
                  end
                  ST_ARMED: begin
                     if (done_rise_c) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                     end
                  end
                  ST_WAIT: begin
                     if (wait_cnt == WAIT_LAST) state    <= ST_SAMPLE;
                     else                       wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
                  ST_SAMPLE: begin
                     accept_q <= 1'b0;
                     state    <= ST_UPDATE;
                     if (!pos_c.valid) begin
                        off_map <= 1'b1;
                     end else if (pos_c.multi) begin
                        pos_err <= 1'b1;
                     end else if (KO_qb == 4'd0) begin
                        cube_idx <= pos_c.idx;
                        accept_q <= 1'b1;
                     end
                  end
                  ST_UPDATE: begin
                     accept_q <= 1'b0;
                     state    <= ST_ARMED;
                     if (accept_q) begin
                        color_state <= color_nx_c;
                        mid_state   <= mid_nx_c;
                        color_cnt   <= cnt_nx_c;
                        land_pulse  <= 1'b1;
                        if (cnt_nx_c == CNT_FULL) state <= ST_DONE;
                     end
                  end
                  ST_DONE: level_done <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_qbert_cube_tracker.sv
// Scoreboard bench for qbert_cube_tracker: a per-cube reference model queues the expected board
// for every accepted landing and a monitor checks it whenever land_pulse fires.
`timescale 1ns/1ps
module tb_qbert_cube_tracker;

   localparam int N      = 28;
   localparam int SETTLE = 2;
   localparam int CNT_W  = 5;

   logic             CLK_33 = 1'b0;
   logic             reset;
   logic             e_start_qb;
   logic             e_pause_qb;
   logic [1:0]       e_rule;
   logic             done_move;
   logic [3:0]       KO_qb;
   logic [N-1:0]     position_qb;
   logic [N-1:0]     color_state;
   logic [N-1:0]     mid_state;
   logic [CNT_W-1:0] color_cnt;
   logic [4:0]       cube_idx;
   logic             land_pulse;
   logic             off_map;
   logic             pos_err;
   logic             level_done;

   qbert_cube_tracker #(.N_CUBE(N), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .CLK_33      (CLK_33),
      .reset       (reset),
      .e_start_qb  (e_start_qb),
      .e_pause_qb  (e_pause_qb),
      .e_rule      (e_rule),
      .done_move   (done_move),
      .KO_qb       (KO_qb),
      .position_qb (position_qb),
      .color_state (color_state),
      .mid_state   (mid_state),
      .color_cnt   (color_cnt),
      .cube_idx    (cube_idx),
      .land_pulse  (land_pulse),
      .off_map     (off_map),
      .pos_err     (pos_err),
      .level_done  (level_done)
   );

   always #5 CLK_33 = ~CLK_33;

   typedef struct {
      logic [N-1:0] color;
      logic [N-1:0] mid;
      int           cnt;
      int           idx;
      int           cyc;
   } exp_t;

   exp_t sbq[$];
   bit   mc[N];
   bit   mm[N];
   int   m_rule;
   bit   m_off, m_perr;
   bit   m_frozen = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always @(posedge CLK_33) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      oh = N'(1) << i;
   endfunction

   function automatic logic [N-1:0] m_color_vec();
      m_color_vec = '0;
      for (int i = 0; i < N; i++) if (mc[i]) m_color_vec |= oh(i);
   endfunction

   function automatic logic [N-1:0] m_mid_vec();
      m_mid_vec = '0;
      for (int i = 0; i < N; i++) if (mm[i]) m_mid_vec |= oh(i);
   endfunction

   function automatic int m_count();
      m_count = 0;
      for (int i = 0; i < N; i++) m_count += int'(mc[i]);
   endfunction

   // Reference behaviour of one landing; queues the expected board when the landing counts.
   task automatic model_land(input logic [N-1:0] pos, input logic [3:0] ko, input int lat);
      int   pc;
      int   idx;
      exp_t e;
      pc  = 0;
      idx = 0;
      for (int i = 0; i < N; i++) if (pos[i]) begin pc++; idx = i; end
      if (m_frozen) return;
      if (pc == 0) m_off = 1'b1;
      else if (pc > 1) m_perr = 1'b1;
      else if (ko == 4'd0) begin
         case (m_rule)
            1: if (!mm[idx]) mm[idx] = 1'b1; else mc[idx] = 1'b1;
            2: mc[idx] = !mc[idx];
            default: mc[idx] = 1'b1;
         endcase
         e.color = m_color_vec();
         e.mid   = m_mid_vec();
         e.cnt   = m_count();
         e.idx   = idx;
         e.cyc   = lat;
         sbq.push_back(e);
         if (e.cnt == N) m_frozen = 1'b1;
      end
   endtask

   // Monitor: every land_pulse must match the oldest queued expectation.
   always @(negedge CLK_33) begin
      if (reset && land_pulse) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_land_pulse: got pulse at cycle %0d want none (cube_idx=%0d)", cyc, cube_idx);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pulse_color", 32'(color_state), 32'(e.color));
            chk("pulse_mid", 32'(mid_state), 32'(e.mid));
            chk("pulse_cnt", 32'(color_cnt), 32'(e.cnt));
            chk("pulse_idx", 32'(cube_idx), 32'(e.idx));
            if (e.cyc >= 0) chk("pulse_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic check_board(input string tag);
      chk({tag, "_off_map"}, 32'(off_map), 32'(m_off));
      chk({tag, "_pos_err"}, 32'(pos_err), 32'(m_perr));
      chk({tag, "_color"}, 32'(color_state), 32'(m_color_vec()));
      chk({tag, "_mid"}, 32'(mid_state), 32'(m_mid_vec()));
      chk({tag, "_level_done"}, 32'(level_done), 32'(m_count() == N));
   endtask

   // Start pulse (optionally together with a done_move rise), then confirm the board is cleared.
   task automatic start_level(input logic [1:0] rule, input bit with_done, input logic [N-1:0] pos);
      @(posedge CLK_33); #1;
      e_rule     = rule;
      e_start_qb = 1'b1;
      if (with_done) begin
         position_qb = pos;
         KO_qb       = 4'd0;
         done_move   = 1'b1;
      end
      repeat (2) @(posedge CLK_33);
      #1 e_start_qb = 1'b0;
      for (int i = 0; i < N; i++) begin mc[i] = 1'b0; mm[i] = 1'b0; end
      m_rule   = int'(rule);
      m_off    = 1'b0;
      m_perr   = 1'b0;
      m_frozen = 1'b0;
      @(posedge CLK_33); #1 done_move = 1'b0;
      @(negedge CLK_33);
      chk("clear_cnt", 32'(color_cnt), 32'd0);
      check_board("clear");
   endtask

   task automatic land(input logic [N-1:0] pos, input logic [3:0] ko);
      @(posedge CLK_33); #1;
      position_qb = pos;
      KO_qb       = ko;
      done_move   = 1'b1;
      model_land(pos, ko, cyc + SETTLE + 3);
      repeat (5) @(posedge CLK_33);
      #1 done_move = 1'b0;
      repeat (4) @(posedge CLK_33);
      @(negedge CLK_33);
      check_board("land");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 50000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] p;
      int a, b, r;
      reset       = 1'b0;
      e_start_qb  = 1'b0;
      e_pause_qb  = 1'b0;
      e_rule      = 2'd0;
      done_move   = 1'b0;
      KO_qb       = 4'd0;
      position_qb = '0;
      repeat (3) @(negedge CLK_33);
      chk("rst_color", 32'(color_state), 32'd0);
      chk("rst_mid", 32'(mid_state), 32'd0);
      chk("rst_cnt", 32'(color_cnt), 32'd0);
      chk("rst_idx", 32'(cube_idx), 32'd0);
      chk("rst_flags", {28'd0, land_pulse, off_map, pos_err, level_done}, 32'd0);
      @(posedge CLK_33); #1 reset = 1'b1;

      // Landing before any start is ignored.
      land(oh(4), 4'd0);

      // ONCE on cubes 0,1,2.
      start_level(2'd0, 1'b0, '0);
      for (int i = 0; i < 3; i++) land(oh(i), 4'd0);
      chk("once_cnt", 32'(color_cnt), 32'd3);

      // TWO_STEP on cube 5; rule input change mid-level must be ignored.
      start_level(2'd1, 1'b0, '0);
      e_rule = 2'd2;
      land(oh(5), 4'd0);
      land(oh(5), 4'd0);
      chk("two_step_cnt", 32'(color_cnt), 32'd1);

      // TOGGLE on cube 27 three times.
      start_level(2'd2, 1'b0, '0);
      for (int i = 0; i < 3; i++) land(oh(27), 4'd0);

      // Off-map, multi-hot and knocked-out samples.
      start_level(2'd0, 1'b0, '0);
      land('0, 4'd0);
      p = N'(3);
      land(p, 4'd0);
      land(oh(7), 4'd9);
      land(oh(8), 4'd0);

      // Pause during WAIT with extra done_move edges.
      start_level(2'd0, 1'b0, '0);
      @(posedge CLK_33); #1;
      position_qb = oh(9);
      KO_qb       = 4'd0;
      done_move   = 1'b1;
      model_land(oh(9), 4'd0, -1);
      repeat (2) @(posedge CLK_33);
      #1 e_pause_qb = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK_33); #1 done_move = ~done_move;
      end
      #1 done_move = 1'b0;
      repeat (3) @(posedge CLK_33);
      @(negedge CLK_33);
      chk("pause_color_held", 32'(color_state), 32'd0);
      chk("pause_pending", 32'(sbq.size()), 32'd1);
      @(posedge CLK_33); #1 e_pause_qb = 1'b0;
      repeat (10) @(posedge CLK_33);
      @(negedge CLK_33);
      chk("pause_queue_empty", 32'(sbq.size()), 32'd0);
      check_board("pause");

      // Start and done_move rise together: start wins.
      start_level(2'd0, 1'b1, oh(3));
      repeat (6) @(posedge CLK_33);
      @(negedge CLK_33);
      chk("simul_color", 32'(color_state), 32'd0);

      // ONCE over all 28 cubes, then a landing in DONE, then restart.
      start_level(2'd3, 1'b0, '0);
      for (int i = 0; i < N; i++) land(oh((i * 11 + 5) % N), 4'd0);
      chk("full_cnt", 32'(color_cnt), 32'(N));
      land(oh(0), 4'd0);
      start_level(2'd0, 1'b0, '0);

      // Randomised levels.
      for (int lvl = 0; lvl < 4; lvl++) begin
         start_level(2'($urandom_range(0, 3)), 1'b0, '0);
         e_rule = 2'($urandom_range(0, 3));
         for (int k = 0; k < 14; k++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : $urandom_range(0, N - 1);
            if (r == 0) land('0, 4'd0);
            else if (r == 1) begin
               b = (a + 1 + $urandom_range(0, N - 2)) % N;
               land(oh(a) | oh(b), 4'd0);
            end else if (r == 2) land(oh(a), 4'($urandom_range(1, 15)));
            else land(oh(a), 4'd0);
         end
         chk("rand_cnt", 32'(color_cnt), 32'(m_count()));
      end

      for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge CLK_33);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
